// File: rtl/dncnt_pkg.sv
// Shared definitions for the countdown controller and the sequencing FSMs that drive it.
package dncnt_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_HOLD = ST_HOLD
    } state_e;

endpackage : dncnt_pkg

// File: rtl/sync_dncnt.sv
// Loadable synchronous down-counter datapath that saturates at zero.
module sync_dncnt #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [N-1:0] ld_val,
    input  logic         dec,
    output logic [N-1:0] q,
    output logic         is_one
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - N'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q      = cnt_q;
    assign is_one = (cnt_q == N'(1));

endmodule : sync_dncnt

// File: rtl/dncnt_ctrl.sv
// Countdown controller: IDLE/RUN/HOLD sequencing, one-shot or auto-reload,
// registered terminal-count pulse. Priority: rst > abort > start > hold > tick.
module dncnt_ctrl
    import dncnt_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         hold,
    input  logic         tick,
    input  logic         auto_reload,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done
);

    state_e       state_q, state_d;
    logic [N-1:0] reload_q, reload_d;
    logic         mode_q, mode_d;
    logic         done_q, done_d;

    logic         cnt_ld;
    logic [N-1:0] cnt_ld_val;
    logic         cnt_dec;
    logic         cnt_is_one;

    sync_dncnt #(.N(N)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_val),
        .dec    (cnt_dec),
        .q      (q),
        .is_one (cnt_is_one)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        reload_d   = reload_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        cnt_ld     = 1'b0;
        cnt_ld_val = load_val;
        cnt_dec    = 1'b0;

        if (abort) begin
            // Force the count to zero; any coincident tick is discarded.
            state_d    = S_IDLE;
            cnt_ld     = 1'b1;
            cnt_ld_val = '0;
        end else if (start) begin
            cnt_ld = 1'b1;
            if (load_val != '0) begin
                state_d  = S_RUN;
                reload_d = load_val;
                mode_d   = auto_reload;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (hold) begin
                        state_d = S_HOLD;
                    end else if (tick) begin
                        if (cnt_is_one) begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                cnt_ld     = 1'b1;
                                cnt_ld_val = reload_q;
                            end else begin
                                cnt_dec = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule : dncnt_ctrl

// File: tb/tb_dncnt_ctrl.sv
// Scoreboard bench for dncnt_ctrl: directed scenarios then random traffic,
// checked against a behavioural countdown model.
module tb_dncnt_ctrl;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst, start, abort, hold, tick, auto_reload;
    logic [N-1:0] load_val;
    logic [N-1:0] q;
    logic         busy, done;

    typedef struct {
        int q;
        bit busy;
        bit done;
    } exp_t;

    exp_t exp_fifo[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model state
    int m_q        = 0;
    int m_reload   = 0;
    bit m_active   = 0;
    bit m_held     = 0;
    bit m_periodic = 0;

    always #5 clk = ~clk;

    dncnt_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .hold        (hold),
        .tick        (tick),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .q           (q),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Applies one cycle of the countdown rules to the model.
    function automatic exp_t model_step(input bit r, a, s, h, t, ar, input int lv);
        exp_t e;
        bit   pulse = 0;
        if (r) begin
            m_q = 0; m_reload = 0; m_active = 0; m_held = 0; m_periodic = 0;
        end else if (a) begin
            m_q = 0; m_active = 0; m_held = 0;
        end else if (s) begin
            if (lv != 0) begin
                m_q = lv; m_reload = lv; m_periodic = ar; m_active = 1; m_held = 0;
            end else begin
                m_q = 0; m_active = 0; m_held = 0; pulse = 1;
            end
        end else if (m_active && m_held) begin
            if (!h) m_held = 0;
        end else if (m_active) begin
            if (h) begin
                m_held = 1;
            end else if (t) begin
                if (m_q == 1) begin
                    pulse = 1;
                    if (m_periodic) m_q = m_reload;
                    else begin
                        m_q = 0; m_active = 0;
                    end
                end else if (m_q > 1) begin
                    m_q = m_q - 1;
                end
            end
        end
        e.q    = m_q;
        e.busy = m_active;
        e.done = pulse;
        return e;
    endfunction

    task automatic step(input bit r, a, s, h, t, ar, input int lv);
        exp_t e;
        rst = r; abort = a; start = s; hold = h; tick = t; auto_reload = ar;
        load_val = N'(lv);
        e = model_step(r, a, s, h, t, ar, lv);
        @(posedge clk);
        exp_fifo.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_fifo.size() > 0) begin
                e = exp_fifo.pop_front();
                check("q",    int'(q),    e.q);
                check("busy", int'(busy), int'(e.busy));
                check("done", int'(done), int'(e.done));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cycles;
        rst = 1; start = 0; abort = 0; hold = 0; tick = 0; auto_reload = 0; load_val = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        idle(2);

        // One-shot countdown from 5
        step(0, 0, 1, 0, 0, 0, 5);
        ticks(6);
        idle(2);

        // Auto-reload of 3, tick every 2nd cycle, 12 ticks
        step(0, 0, 1, 0, 0, 1, 3);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            idle(1);
        end
        step(0, 1, 0, 0, 0, 0, 0);

        // Hold freezes the count and drops ticks
        step(0, 0, 1, 0, 0, 0, 10);
        ticks(2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        ticks(1);
        step(0, 1, 0, 0, 0, 0, 0);

        // Abort with a coincident tick at q=4
        step(0, 0, 1, 0, 0, 0, 6);
        ticks(2);
        step(0, 1, 0, 0, 1, 0, 0);
        idle(2);

        // Restart mid-count, then zero load from IDLE
        step(0, 0, 1, 0, 0, 0, 9);
        ticks(7);
        step(0, 0, 1, 0, 0, 0, 63);
        ticks(2);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        idle(2);

        // Restart while held, and a period-1 auto-reload
        step(0, 0, 1, 0, 0, 0, 4);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        ticks(3);
        step(0, 1, 0, 0, 0, 0, 0);

        // Reset mid-count; ticks afterwards are ignored
        step(0, 0, 1, 0, 0, 0, 30);
        ticks(10);
        step(1, 0, 0, 0, 1, 0, 0);
        ticks(3);

        // Random traffic
        begin
            bit h_lvl = 0;
            for (int i = 0; i < 4000; i++) begin
                bit r, a, s, t, ar;
                int lv;
                r  = ($urandom_range(0, 199) == 0);
                a  = ($urandom_range(0, 39) == 0);
                s  = ($urandom_range(0, 19) == 0);
                t  = ($urandom_range(0, 1) == 1);
                ar = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 9) == 0) h_lvl = ~h_lvl;
                case ($urandom_range(0, 9))
                    0:       lv = 0;
                    1, 2, 3: lv = $urandom_range(1, 3);
                    default: lv = $urandom_range(0, (1 << N) - 1);
                endcase
                step(r, a, s, h_lvl, t, ar, lv);
            end
        end
        idle(2);

        wait_cycles = 0;
        while (exp_fifo.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        check("drain", exp_fifo.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dncnt_ctrl
